// File: rtl/melody_playlist_scheduler.sv
// Playlist scheduler for the melody sequencer: walks tracks, repeats plays, inserts gaps, obeys start/stop/skip.
// Build option PLAYLIST_GAP_EN adds a GAP_CLOCKS silence counter once the sequencer reports idle.
module melody_playlist_scheduler #(
  parameter int NUM_TRACKS = 4,
  parameter int TRACK_W    = 2,
  parameter int GAP_CLOCKS = 25_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     skip,
  input  logic                     repeat_all,
  input  logic [NUM_TRACKS*32-1:0] tempo_table,
  input  logic [NUM_TRACKS*4-1:0]  repeat_table,
  input  logic                     seq_melody_end,
  input  logic                     seq_playing,
  output logic                     seq_enable,
  output logic                     seq_loop,
  output logic [31:0]              seq_tempo_clocks,
  output logic [TRACK_W-1:0]       track_sel,
  output logic [3:0]               rep_cnt,
  output logic                     busy,
  output logic                     playlist_done,
  output logic [1:0]               dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, GAP = 2'd2} state_e;
  localparam logic [TRACK_W-1:0] LAST_TRACK = TRACK_W'(NUM_TRACKS - 1);

  state_e             state_q, state_d;
  logic [TRACK_W-1:0] track_q, track_d, next_track;
  logic [3:0]         rep_q, rep_d, cur_repeats, eff_repeats;
  logic [31:0]        tempo_q, tempo_d;
  logic               done_q, done_d;
  logic               advance, gap_restart, gap_done;

  assign cur_repeats = repeat_table[int'(track_q)*4 +: 4];
  assign eff_repeats = (cur_repeats == 4'd0) ? 4'd1 : cur_repeats;
  assign next_track  = (track_q == LAST_TRACK) ? '0 : track_q + 1'b1;

`ifdef PLAYLIST_GAP_EN
  // The counter arms on the first GAP cycle with the sequencer idle, then runs GAP_CLOCKS cycles.
  logic        gap_armed_q, gap_armed_d;
  logic [31:0] gap_cnt_q, gap_cnt_d;

  assign gap_done = gap_armed_q ? (gap_cnt_q == 32'(GAP_CLOCKS - 1))
                                : (!seq_playing && (GAP_CLOCKS == 0));

  always_comb begin
    gap_armed_d = gap_armed_q;
    gap_cnt_d   = gap_cnt_q;
    if (state_q != GAP || gap_restart) begin
      gap_armed_d = 1'b0;
      gap_cnt_d   = '0;
    end else if (!gap_armed_q) begin
      gap_armed_d = !seq_playing;
    end else begin
      gap_cnt_d = gap_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_armed_q <= 1'b0;
      gap_cnt_q   <= '0;
    end else begin
      gap_armed_q <= gap_armed_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end
`else
  assign gap_done = !seq_playing;
`endif

  // Command priority: stop > skip > end-of-melody > start; gap expiry only when nothing else acts.
  always_comb begin
    state_d     = state_q;
    track_d     = track_q;
    rep_d       = rep_q;
    tempo_d     = tempo_q;
    done_d      = 1'b0;
    advance     = 1'b0;
    gap_restart = 1'b0;
    if (stop && state_q != IDLE) begin
      state_d = IDLE;
    end else if (skip && state_q != IDLE) begin
      advance = 1'b1;
    end else if (seq_melody_end && state_q == RUN) begin
      if (({1'b0, rep_q} + 5'd1) < {1'b0, eff_repeats}) begin
        rep_d       = (rep_q == 4'd15) ? rep_q : rep_q + 4'd1;
        state_d     = GAP;
        gap_restart = 1'b1;
      end else begin
        advance = 1'b1;
      end
    end else if (start && state_q == IDLE) begin
      track_d = '0;
      rep_d   = '0;
      tempo_d = tempo_table[31:0];
      state_d = RUN;
    end else if (state_q == GAP && gap_done) begin
      state_d = RUN;
    end

    if (advance) begin
      if (track_q == LAST_TRACK && !repeat_all) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        track_d     = next_track;
        rep_d       = '0;
        tempo_d     = tempo_table[int'(next_track)*32 +: 32];
        state_d     = GAP;
        gap_restart = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      track_q <= '0;
      rep_q   <= '0;
      tempo_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      track_q <= track_d;
      rep_q   <= rep_d;
      tempo_q <= tempo_d;
      done_q  <= done_d;
    end
  end

  // Drop enable in the end-pulse cycle so the sequencer cannot restart before RUN is left.
  assign seq_enable       = (state_q == RUN) & ~seq_melody_end;
  assign seq_loop         = 1'b0;
  assign seq_tempo_clocks = tempo_q;
  assign track_sel        = track_q;
  assign rep_cnt          = rep_q;
  assign busy             = (state_q != IDLE);
  assign playlist_done    = done_q;
  assign dbg_state        = state_q;
endmodule

// File: tb/tb_melody_playlist_scheduler.sv
// Bench for melody_playlist_scheduler: a sequencer model plays each track while a play-list model
// (track, repeat) derived from the tables predicts every play, gap length and done pulse.
module tb_melody_playlist_scheduler;
  localparam int NT  = 4;
  localparam int TW  = 2;
  localparam int GAP = 10;
`ifdef PLAYLIST_GAP_EN
  localparam int G_EFF = GAP;
`else
  localparam int G_EFF = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, stop = 1'b0, skip = 1'b0, repeat_all = 1'b0;
  logic [NT*32-1:0] tempo_table = '0;
  logic [NT*4-1:0]  repeat_table = '0;
  logic          seq_melody_end = 1'b0, seq_playing = 1'b0;
  logic          seq_enable, seq_loop, busy, playlist_done;
  logic [31:0]   seq_tempo_clocks;
  logic [TW-1:0] track_sel;
  logic [3:0]    rep_cnt;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  melody_playlist_scheduler #(.NUM_TRACKS(NT), .TRACK_W(TW), .GAP_CLOCKS(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .skip(skip), .repeat_all(repeat_all),
    .tempo_table(tempo_table), .repeat_table(repeat_table),
    .seq_melody_end(seq_melody_end), .seq_playing(seq_playing),
    .seq_enable(seq_enable), .seq_loop(seq_loop), .seq_tempo_clocks(seq_tempo_clocks),
    .track_sel(track_sel), .rep_cnt(rep_cnt), .busy(busy), .playlist_done(playlist_done),
    .dbg_state(dbg_state)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int eff_rep(input int t);
    int r;
    r = int'(repeat_table[t*4 +: 4]);
    return (r == 0) ? 1 : r;
  endfunction

  function automatic logic [31:0] tempo_of(input int t);
    return tempo_table[t*32 +: 32];
  endfunction

  // Every play of the list in order, packed as {track, completed repeats}.
  task automatic build_plays(input int n_limit);
    int t;
    t = 0;
    exp_q.delete();
    while (exp_q.size() < n_limit) begin
      for (int r = 0; r < eff_rep(t) && exp_q.size() < n_limit; r++)
        exp_q.push_back({4'(t), 4'(r)});
      if (t == NT - 1) begin
        if (!repeat_all) break;
        t = 0;
      end else begin
        t++;
      end
    end
  endtask

  task automatic randomize_tempo;
    for (int i = 0; i < NT; i++)
      tempo_table[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom());
  endtask

  task automatic check_entry(input logic [7:0] e, input string tag);
    total++;
    if (seq_enable !== 1'b1 || busy !== 1'b1 || 4'(track_sel) !== e[7:4] || rep_cnt !== e[3:0] ||
        seq_tempo_clocks !== tempo_of(int'(e[7:4]))) begin
      bad++;
      $display("FAIL %s: en=%0b busy=%0b track=%0d rep=%0d tempo=%0d want track=%0d rep=%0d tempo=%0d",
               tag, seq_enable, busy, track_sel, rep_cnt, seq_tempo_clocks, e[7:4], e[3:0],
               tempo_of(int'(e[7:4])));
    end
  endtask

  // Sequencer model: plays len cycles, ends, keeps playing tail more cycles, then measures the gap.
  task automatic run_play(input int len, input int tail, input bit last);
    int low;
    bit ok;
    seq_playing = 1'b1;
    repeat (len) tick;
    seq_melody_end = 1'b1;
    #1;
    total++;
    if (seq_enable !== 1'b0) begin
      bad++;
      $display("FAIL end_cut: seq_enable=%0b want 0", seq_enable);
    end
    tick;
    seq_melody_end = 1'b0;
    total++;
    if (playlist_done !== last) begin
      bad++;
      $display("FAIL done_pulse: playlist_done=%0b want %0b", playlist_done, last);
    end
    if (last) begin
      seq_playing = 1'b0;
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL done_busy: busy=%0b want 0", busy);
      end
      tick;
      total++;
      if (playlist_done !== 1'b0) begin
        bad++;
        $display("FAIL done_width: playlist_done=%0b want 0", playlist_done);
      end
    end else begin
      low = 1;
      ok = 1'b0;
      for (int c = 1; c < 200; c++) begin
        seq_playing = (c <= tail);
        #1;
        if (seq_enable) begin
          ok = 1'b1;
          break;
        end
        low++;
        tick;
      end
      total++;
      if (!ok || low != tail + G_EFF + 2) begin
        bad++;
        $display("FAIL gap_len: low=%0d seen=%0b want %0d", low, ok, tail + G_EFF + 2);
      end
    end
  endtask

  task automatic run_sequence(input int n_limit, input string tag);
    logic [7:0] e;
    int n;
    build_plays(n_limit);
    n = exp_q.size();
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int p = 0; p < n; p++) begin
      e = exp_q.pop_front();
      check_entry(e, tag);
      if (p == n - 1 && repeat_all) break;
      run_play($urandom_range(1, 8), $urandom_range(0, 3), (p == n - 1) && !repeat_all);
    end
    if (repeat_all) begin
      stop = 1'b1;
      tick;
      stop = 1'b0;
      total++;
      if (busy !== 1'b0 || playlist_done !== 1'b0) begin
        bad++;
        $display("FAIL %s_stop: busy=%0b done=%0b want 0 0", tag, busy, playlist_done);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) tick;
    total++;
    if (seq_enable !== 0 || seq_loop !== 0 || seq_tempo_clocks !== 0 || track_sel !== 0 ||
        rep_cnt !== 0 || busy !== 0 || playlist_done !== 0) begin
      bad++;
      $display("FAIL reset: en=%0b loop=%0b tempo=%0d track=%0d rep=%0d busy=%0b done=%0b want all 0",
               seq_enable, seq_loop, seq_tempo_clocks, track_sel, rep_cnt, busy, playlist_done);
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic_tempo;
    repeat_all = 1'b0;
    repeat_table = {4'd1, 4'd1, 4'd1, 4'd1};
    tempo_table = {32'd400, 32'd250, 32'd0, 32'd100};
    run_sequence(1000, "basic");
  endtask

  task automatic test_repeats;
    for (int k = 0; k < 3; k++) begin
      randomize_tempo();
      for (int i = 0; i < NT; i++) repeat_table[i*4 +: 4] = 4'($urandom_range(0, 2));
      repeat_table[7:4] = 4'd3;
      run_sequence(1000, "repeats");
    end
  endtask

  task automatic test_repeat_all;
    repeat_all = 1'b1;
    randomize_tempo();
    repeat_table = {4'd1, 4'd1, 4'd1, 4'd1};
    run_sequence(NT + 1, "wrap");
    repeat_all = 1'b0;
  endtask

  task automatic test_skip;
    int low;
    bit ok;
    randomize_tempo();
    repeat_table = {4'd1, 4'd1, 4'd1, 4'd1};
    start = 1'b1;
    tick;
    start = 1'b0;
    run_play(3, 1, 1'b0);
    run_play(2, 0, 1'b0);
    seq_playing = 1'b1;
    repeat (3) tick;
    skip = 1'b1;
    tick;
    skip = 1'b0;
    low = 0;
    ok = 1'b0;
    for (int c = 1; c < 200; c++) begin
      seq_playing = (c <= 5);
      #1;
      if (seq_enable) begin
        ok = 1'b1;
        break;
      end
      low++;
      tick;
    end
    total++;
    if (!ok || low != 5 + G_EFF + 1) begin
      bad++;
      $display("FAIL skip_gap: low=%0d seen=%0b want %0d", low, ok, 5 + G_EFF + 1);
    end
    check_entry({4'd3, 4'd0}, "skip_track");
    run_play(2, 0, 1'b1);
  endtask

  task automatic test_stop_skip;
    randomize_tempo();
    repeat_table = {4'd1, 4'd1, 4'd1, 4'd1};
    start = 1'b1;
    tick;
    start = 1'b0;
    run_play($urandom_range(1, 6), 0, 1'b0);
    seq_playing = 1'b1;
    repeat (2) tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    check_entry({4'd1, 4'd0}, "start_busy");
    stop = 1'b1;
    skip = 1'b1;
    tick;
    stop = 1'b0;
    skip = 1'b0;
    seq_playing = 1'b0;
    total++;
    if (busy !== 0 || seq_enable !== 0 || track_sel !== 2'd1 || rep_cnt !== 0 || playlist_done !== 0) begin
      bad++;
      $display("FAIL stop_skip: busy=%0b en=%0b track=%0d rep=%0d done=%0b want 0 0 1 0 0",
               busy, seq_enable, track_sel, rep_cnt, playlist_done);
    end
    tick;
    total++;
    if (playlist_done !== 0 || busy !== 0) begin
      bad++;
      $display("FAIL stop_hold: done=%0b busy=%0b want 0 0", playlist_done, busy);
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    check_entry({4'd0, 4'd0}, "restart");
    stop = 1'b1;
    tick;
    stop = 1'b0;
    total++;
    if (busy !== 0 || seq_enable !== 0) begin
      bad++;
      $display("FAIL stop_run: busy=%0b en=%0b want 0 0", busy, seq_enable);
    end
  endtask

  initial begin
    test_reset();
    test_basic_tempo();
    test_repeats();
    test_repeat_all();
    test_skip();
    test_stop_skip();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/melody_playlist_scheduler.md
# melody_playlist_scheduler

Sequences the melody sequencer through a playlist of up to NUM_TRACKS melodies stored in banked melody ROM. Drives the sequencer's enable, loop and tempo inputs and the ROM bank select, plays each track a programmable number of times, inserts a silent gap between plays and handles start/stop/skip commands from the control register block. Sits between the control interface and the melody sequencer; the sequencer's own loop mode is never used.

## Interface
- NUM_TRACKS, 4, playlist length (2..16)
- TRACK_W, 2, width of track index, clog2(NUM_TRACKS)
- GAP_CLOCKS, 25_000_000, silent clocks between plays (0 = no gap)
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous and active-low
- start  in  1  one-cycle pulse: begin playlist at track 0 (ignored while busy)
- stop  in  1  one-cycle pulse: abort and return to IDLE
- skip  in  1  one-cycle pulse: abandon current track, advance to next
- repeat_all  in  1  wrap from last track to track 0 instead of finishing
- tempo_table  in  NUM_TRACKS*32  per-track clocks-per-16th, entry i at [32i+31:32i]
- repeat_table  in  NUM_TRACKS*4  per-track play count, 0 treated as 1
- seq_melody_end  in  1  end-of-melody pulse from sequencer
- seq_playing  in  1  sequencer playing status
- seq_enable  out  1  sequencer enable
- seq_loop  out  1  tied 0
- seq_tempo_clocks  out  32  tempo for current track
- track_sel  out  TRACK_W  ROM bank select / current track
- rep_cnt  out  4  completed plays of current track
- busy  out  1  high in any state except IDLE
- playlist_done  out  1  one-cycle pulse when playlist finishes

## Operation
- Reset: all outputs 0; state IDLE.
- States: IDLE, RUN, GAP.
- IDLE: run_q=0. start -> track_sel=0, rep_cnt=0, seq_tempo_clocks=tempo_table[0], go RUN.
- RUN: run_q=1. On seq_melody_end: if rep_cnt+1 < eff_repeats(track_sel): rep_cnt+1, go GAP (same track). Else advance: if track_sel==NUM_TRACKS-1 and !repeat_all, pulse playlist_done, go IDLE; else track_sel = track_sel+1 (wrap to 0 after last), rep_cnt=0, go GAP.
- GAP: run_q=0. Wait until seq_playing==0, then count GAP_CLOCKS cycles, then go RUN.
- seq_enable = run_q & ~seq_melody_end (only combinational output path; prevents the sequencer restarting from IDLE in the cycle the end pulse is seen).
- seq_tempo_clocks reloaded from tempo_table whenever track_sel changes; value 0 passed through unchanged (sequencer falls back to its default).
- Priority in one cycle: stop > skip > seq_melody_end > start.
- stop (any non-IDLE state): go IDLE, run_q=0, track_sel/rep_cnt hold, no playlist_done.
- skip in RUN or GAP: advance exactly as end-of-last-repeat (including done/wrap), go GAP; GAP counter restarts. skip in IDLE ignored.
- Track index wraps NUM_TRACKS-1 -> 0; rep_cnt saturates at 15.

## Timing
- start at cycle T -> busy and seq_enable high at T+1.
- seq_melody_end at T -> seq_enable low at T; run_q low at T+1.
- GAP exit: GAP_CLOCKS cycles after first cycle with seq_playing==0 in GAP; seq_enable high the following cycle.
- GAP_CLOCKS=0: RUN re-entered the cycle after seq_playing==0 is seen.
- stop at T -> seq_enable low T+1, busy low T+1.
- playlist_done high exactly one cycle, coincident with busy going low.

## Configuration
- PLAYLIST_GAP_EN defined: GAP counter present, behaviour as above.
- Undefined: counter removed; GAP waits only for seq_playing==0 then returns to RUN (GAP_CLOCKS ignored).

## Test plan
- NUM_TRACKS=4, repeats {1,1,1,1}, GAP_CLOCKS=10, start; sequencer model ends each track -> track_sel 0,1,2,3, seq_enable low ≥10 cycles between plays, playlist_done once, busy low after.
- repeat_table[1]=3 -> track 1 played 3 times, rep_cnt 0,1,2, then track_sel=2 with rep_cnt=0.
- repeat_all=1 -> after track 3 ends, track_sel=0, no playlist_done, busy stays high.
- skip mid-track 2 with seq_playing held high 5 cycles -> seq_enable low until playing drops, then gap, track_sel=3.
- stop and skip same cycle during RUN -> IDLE next cycle, track_sel unchanged, no done pulse; start after -> track_sel=0.
- tempo_table {100,0,250,400}: seq_tempo_clocks follows 100,0,250,400 on each track change; seq_enable low in same cycle as every seq_melody_end.
